// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Registered control path for a 5-stage RISC-V pipeline.
//   - The ID stage decodes op/func3/func7 for lw, sw, R, B, I, jal, jalr and lui.
//   - The decoded controls travel through the ID/EX, EX/MEM and MEM/WB
//     control registers.
//   - stall or flush loads a bubble (all controls 0) into ID/EX.
//   - A halt token drains the pipeline before the sticky done flag asserts.
//
// Configuration macro:
//   MUL_EXT_EN  When defined, R-type func7=0000001 func3=000 decodes as
//               mul (aluControl 110). When undefined, that encoding decodes
//               as add.
//
// Parameters:
//   HALT_OP      opcode treated as a halt
//   STRICT_HALT  1: only HALT_OP halts; 0: any unknown nonzero opcode halts
//   DONE_DELAY   extra cycles (0..15) after the token leaves WB before done
//
// Ports:
//   clk, rst                        rising-edge clock, async active-high reset
//   op_D, func3_D, func7_D          instruction fields in ID
//   stall, flush                    bubble requests for ID/EX
//   immSrc_D                        immediate select (combinational, ID)
//   aluControl_E, aluSrc_E          ALU controls in EX
//   beq_E, bne_E, blt_E, bge_E      branch type in EX
//   jmp_E, jalrSel_E                jump controls in EX
//   resultSrc_E, regWrite_E         exported for hazard detection/forwarding
//   memWrite_M, regWrite_M,
//   resultSrc_M                     MEM stage controls
//   regWrite_W, resultSrc_W         WB stage controls
//   done                            sticky halt-complete flag
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter logic [6:0] HALT_OP     = 7'b1111111,
    parameter bit          STRICT_HALT = 1'b0,
    parameter int          DONE_DELAY  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_D,
    input  logic [2:0] func3_D,
    input  logic [6:0] func7_D,
    input  logic       stall,
    input  logic       flush,
    output logic [2:0] immSrc_D,
    output logic [2:0] aluControl_E,
    output logic       aluSrc_E,
    output logic       beq_E,
    output logic       bne_E,
    output logic       blt_E,
    output logic       bge_E,
    output logic       jmp_E,
    output logic       jalrSel_E,
    output logic [1:0] resultSrc_E,
    output logic       regWrite_E,
    output logic       memWrite_M,
    output logic       regWrite_M,
    output logic [1:0] resultSrc_M,
    output logic       regWrite_W,
    output logic [1:0] resultSrc_W,
    output logic       done
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] DELAY_CNT = 4'(DONE_DELAY);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jmp;
        logic       jalr_sel;
        logic       beq;
        logic       bne;
        logic       blt;
        logic       bge;
        logic [2:0] alu_control;
        logic       alu_src;
        logic       halt;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t     state;
    ctrl_t      ctrl_D;
    ctrl_t      ctrl_E;
    logic [2:0] imm_src;
    logic       load_bubble;
    logic       mem_write_m;
    logic       reg_write_m;
    logic [1:0] result_src_m;
    logic       halt_M;
    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic       halt_W;
    logic [3:0] delay_cnt;
    logic       waiting;

    // Shared func3 ALU map for R and I classes. Only R-type can select sub
    // (or mul); an I-type func3=000 is always addi regardless of func7.
    function automatic logic [2:0] alu_map(input logic [2:0] f3,
                                           input logic       r_type,
                                           input logic [6:0] f7);
        logic [2:0] code;
        case (f3)
            3'b000: begin
                code = 3'b000;
                if (r_type && f7 == 7'b0100000)
                    code = 3'b001;
`ifdef MUL_EXT_EN
                if (r_type && f7 == 7'b0000001)
                    code = 3'b110;
`endif
            end
            3'b010:  code = 3'b101;
            3'b100:  code = 3'b111;
            3'b110:  code = 3'b011;
            3'b111:  code = 3'b010;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // ID decode. The halt token carries only the halt bit, never any
    // write enable, so it cannot disturb architectural state as it drains.
    always_comb begin
        ctrl_D  = '0;
        imm_src = 3'b000;
        if (op_D == HALT_OP && op_D != 7'd0) begin
            ctrl_D.halt = 1'b1;
        end else begin
            case (op_D)
                7'b0000000: begin
                end
                OP_LW: begin
                    ctrl_D.reg_write  = 1'b1;
                    ctrl_D.result_src = 2'b01;
                    ctrl_D.alu_src    = 1'b1;
                end
                OP_SW: begin
                    ctrl_D.mem_write = 1'b1;
                    ctrl_D.alu_src   = 1'b1;
                    imm_src          = 3'b001;
                end
                OP_R: begin
                    ctrl_D.reg_write   = 1'b1;
                    ctrl_D.alu_control = alu_map(func3_D, 1'b1, func7_D);
                end
                OP_I: begin
                    ctrl_D.reg_write   = 1'b1;
                    ctrl_D.alu_src     = 1'b1;
                    ctrl_D.alu_control = alu_map(func3_D, 1'b0, func7_D);
                end
                OP_B: begin
                    ctrl_D.alu_control = 3'b001;
                    imm_src            = 3'b010;
                    ctrl_D.beq         = (func3_D == 3'b000);
                    ctrl_D.bne         = (func3_D == 3'b001);
                    ctrl_D.blt         = (func3_D == 3'b100);
                    ctrl_D.bge         = (func3_D == 3'b101);
                end
                OP_JAL: begin
                    ctrl_D.reg_write  = 1'b1;
                    ctrl_D.result_src = 2'b10;
                    ctrl_D.jmp        = 1'b1;
                    imm_src           = 3'b011;
                end
                OP_JALR: begin
                    ctrl_D.reg_write  = 1'b1;
                    ctrl_D.result_src = 2'b10;
                    ctrl_D.jmp        = 1'b1;
                    ctrl_D.jalr_sel   = 1'b1;
                    ctrl_D.alu_src    = 1'b1;
                end
                OP_LUI: begin
                    ctrl_D.reg_write   = 1'b1;
                    ctrl_D.alu_src     = 1'b1;
                    ctrl_D.alu_control = 3'b100;
                    imm_src            = 3'b100;
                end
                default: begin
                    ctrl_D.halt = !STRICT_HALT;
                end
            endcase
        end
    end

    // Once a halt has been accepted, nothing younger may enter EX.
    assign load_bubble = stall | flush | (state != ST_RUN);

    // Stage control registers; EX/MEM and MEM/WB always advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_E       <= '0;
            mem_write_m  <= 1'b0;
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            halt_M       <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            halt_W       <= 1'b0;
        end else begin
            ctrl_E       <= load_bubble ? '0 : ctrl_D;
            mem_write_m  <= ctrl_E.mem_write;
            reg_write_m  <= ctrl_E.reg_write;
            result_src_m <= ctrl_E.result_src;
            halt_M       <= ctrl_E.halt;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            halt_W       <= halt_M;
        end
    end

    // Halt sequencing. The edge that sees the token in MEM/WB is the edge it
    // leaves; from there the delay counter runs until it matches DONE_DELAY.
    // 'waiting' keeps the count going after the one-cycle token is gone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            delay_cnt <= 4'd0;
            waiting   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ctrl_D.halt && !stall && !flush)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (halt_W || waiting) begin
                        if (delay_cnt == DELAY_CNT) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            waiting <= 1'b0;
                        end else begin
                            delay_cnt <= delay_cnt + 4'd1;
                            waiting   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign immSrc_D     = imm_src;
    assign aluControl_E = ctrl_E.alu_control;
    assign aluSrc_E     = ctrl_E.alu_src;
    assign beq_E        = ctrl_E.beq;
    assign bne_E        = ctrl_E.bne;
    assign blt_E        = ctrl_E.blt;
    assign bge_E        = ctrl_E.bge;
    assign jmp_E        = ctrl_E.jmp;
    assign jalrSel_E    = ctrl_E.jalr_sel;
    assign resultSrc_E  = ctrl_E.result_src;
    assign regWrite_E   = ctrl_E.reg_write;
    assign memWrite_M   = mem_write_m;
    assign regWrite_M   = reg_write_m;
    assign resultSrc_M  = result_src_m;
    assign regWrite_W   = reg_write_w;
    assign resultSrc_W  = result_src_w;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_unit
// Scoreboard bench for pipe_ctrl_unit. Two instances share the stimulus:
//   u_dut  default parameters (non-strict halt, DONE_DELAY=0)
//   u_dut2 STRICT_HALT=1, DONE_DELAY=3
// Each directed vector pushes hand-computed expectations for its ID, EX,
// MEM and WB appearances; a monitor on the falling edge pops and compares
// whatever is due on that cycle.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_HALT = 7'b1111111;
    localparam logic [6:0] OP_UNK  = 7'b0001111;

`ifdef MUL_EXT_EN
    localparam logic [2:0] MUL_CODE = 3'b110;
`else
    localparam logic [2:0] MUL_CODE = 3'b000;
`endif

    localparam int K_IMM = 0;
    localparam int K_E1  = 1;
    localparam int K_M1  = 2;
    localparam int K_W1  = 3;
    localparam int K_D1  = 4;
    localparam int K_E2  = 5;
    localparam int K_D2  = 6;

    logic       clk;
    logic       rst;
    logic [6:0] op_D;
    logic [2:0] func3_D;
    logic [6:0] func7_D;
    logic       stall;
    logic       flush;

    logic [2:0] immSrc_D, aluControl_E, immSrc2, aluControl2;
    logic       aluSrc_E, beq_E, bne_E, blt_E, bge_E, jmp_E, jalrSel_E, regWrite_E;
    logic       aluSrc2, beq2, bne2, blt2, bge2, jmp2, jalrSel2, regWrite2;
    logic [1:0] resultSrc_E, resultSrc_M, resultSrc_W, resultSrc2E, resultSrc2M, resultSrc2W;
    logic       memWrite_M, regWrite_M, regWrite_W, done;
    logic       memWrite2M, regWrite2M, regWrite2W, done2;

    typedef struct {
        int          kind;
        int          due;
        string       name;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    sb_t keep[$];
    int  edges = 0;
    int  testsRun = 0;
    int  testsFailed = 0;

    pipe_ctrl_unit u_dut (
        .clk(clk), .rst(rst), .op_D(op_D), .func3_D(func3_D), .func7_D(func7_D),
        .stall(stall), .flush(flush), .immSrc_D(immSrc_D),
        .aluControl_E(aluControl_E), .aluSrc_E(aluSrc_E),
        .beq_E(beq_E), .bne_E(bne_E), .blt_E(blt_E), .bge_E(bge_E),
        .jmp_E(jmp_E), .jalrSel_E(jalrSel_E), .resultSrc_E(resultSrc_E),
        .regWrite_E(regWrite_E), .memWrite_M(memWrite_M), .regWrite_M(regWrite_M),
        .resultSrc_M(resultSrc_M), .regWrite_W(regWrite_W), .resultSrc_W(resultSrc_W),
        .done(done)
    );

    pipe_ctrl_unit #(.HALT_OP(7'b1111111), .STRICT_HALT(1'b1), .DONE_DELAY(3)) u_dut2 (
        .clk(clk), .rst(rst), .op_D(op_D), .func3_D(func3_D), .func7_D(func7_D),
        .stall(stall), .flush(flush), .immSrc_D(immSrc2),
        .aluControl_E(aluControl2), .aluSrc_E(aluSrc2),
        .beq_E(beq2), .bne_E(bne2), .blt_E(blt2), .bge_E(bge2),
        .jmp_E(jmp2), .jalrSel_E(jalrSel2), .resultSrc_E(resultSrc2E),
        .regWrite_E(regWrite2), .memWrite_M(memWrite2M), .regWrite_M(regWrite2M),
        .resultSrc_M(resultSrc2M), .regWrite_W(regWrite2W), .resultSrc_W(resultSrc2W),
        .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    // Expected EX vector: {alu, aluSrc, beq, bne, blt, bge, jmp, jalrSel, resultSrc, regWrite}
    function automatic logic [12:0] ev(input logic [2:0] alu, input logic src,
                                       input logic [3:0] br, input logic jmp,
                                       input logic jalr, input logic [1:0] rs,
                                       input logic rw);
        return {alu, src, br, jmp, jalr, rs, rw};
    endfunction

    function automatic logic [15:0] actualOf(input int kind);
        case (kind)
            K_IMM:   return 16'(immSrc_D);
            K_E1:    return 16'({aluControl_E, aluSrc_E, beq_E, bne_E, blt_E, bge_E,
                                 jmp_E, jalrSel_E, resultSrc_E, regWrite_E});
            K_M1:    return 16'({memWrite_M, regWrite_M, resultSrc_M});
            K_W1:    return 16'({regWrite_W, resultSrc_W});
            K_D1:    return 16'(done);
            K_E2:    return 16'({aluControl2, aluSrc2, beq2, bne2, blt2, bge2,
                                 jmp2, jalrSel2, resultSrc2E, regWrite2});
            default: return 16'(done2);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int due, input string name,
                        input logic [15:0] exp);
        sb_t e;
        e.kind = kind;
        e.due  = due;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Monitor: compare everything due on this cycle, keep the rest.
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == edges)
                checkOutput(sb[i].name, actualOf(sb[i].kind), sb[i].exp);
            else
                keep.push_back(sb[i]);
        end
        sb = keep;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string name, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic st, input logic fl,
                                 input logic [2:0] expImm, input logic [12:0] expE,
                                 input logic [3:0] expM, input logic [2:0] expW,
                                 input logic [12:0] expE2);
        op_D    = op;
        func3_D = f3;
        func7_D = f7;
        stall   = st;
        flush   = fl;
        push(K_IMM, edges,     {name, "/immD"}, 16'(expImm));
        push(K_E1,  edges + 1, {name, "/E"},    16'(expE));
        push(K_M1,  edges + 2, {name, "/M"},    16'(expM));
        push(K_W1,  edges + 3, {name, "/W"},    16'(expW));
        push(K_E2,  edges + 1, {name, "/E2"},   16'(expE2));
        step();
    endtask

    task automatic pushAllZero(input string name);
        push(K_E1, edges, {name, "/E"}, 16'd0);
        push(K_M1, edges, {name, "/M"}, 16'd0);
        push(K_W1, edges, {name, "/W"}, 16'd0);
        push(K_D1, edges, {name, "/done"}, 16'd0);
        push(K_E2, edges, {name, "/E2"}, 16'd0);
        push(K_D2, edges, {name, "/done2"}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [12:0] eAdd, eLw, eSw, eJal, eJalr, eLui, eAddi;
        int base;
        eAdd  = ev(3'b000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1);
        eLw   = ev(3'b000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b1);
        eSw   = ev(3'b000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
        eJal  = ev(3'b000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b10, 1'b1);
        eJalr = ev(3'b000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'b10, 1'b1);
        eLui  = ev(3'b100, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1);
        eAddi = ev(3'b000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1);

        rst = 1'b1; op_D = 7'd0; func3_D = 3'd0; func7_D = 7'd0;
        stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pushAllZero("reset");
        step();

        // Decode and latency of each op class.
        applyStimulus("add",  OP_R,  3'b000, 7'b0000000, 0, 0, 3'b000, eAdd, 4'b0100, 3'b100, eAdd);
        applyStimulus("sub",  OP_R,  3'b000, 7'b0100000, 0, 0, 3'b000,
                      ev(3'b001, 0, 4'b0000, 0, 0, 2'b00, 1), 4'b0100, 3'b100,
                      ev(3'b001, 0, 4'b0000, 0, 0, 2'b00, 1));
        applyStimulus("lw",   OP_LW, 3'b010, 7'b0000000, 0, 0, 3'b000, eLw, 4'b0101, 3'b101, eLw);
        applyStimulus("swStall", OP_SW, 3'b010, 7'b0000000, 1, 0, 3'b001, 13'd0, 4'b0000, 3'b000, 13'd0);
        applyStimulus("sw",   OP_SW, 3'b010, 7'b0000000, 0, 0, 3'b001, eSw, 4'b1000, 3'b000, eSw);
        applyStimulus("beq",  OP_B,  3'b000, 7'b0000000, 0, 0, 3'b010,
                      ev(3'b001, 0, 4'b1000, 0, 0, 2'b00, 0), 4'b0000, 3'b000,
                      ev(3'b001, 0, 4'b1000, 0, 0, 2'b00, 0));
        applyStimulus("bne",  OP_B,  3'b001, 7'b0000000, 0, 0, 3'b010,
                      ev(3'b001, 0, 4'b0100, 0, 0, 2'b00, 0), 4'b0000, 3'b000,
                      ev(3'b001, 0, 4'b0100, 0, 0, 2'b00, 0));
        applyStimulus("blt",  OP_B,  3'b100, 7'b0000000, 0, 0, 3'b010,
                      ev(3'b001, 0, 4'b0010, 0, 0, 2'b00, 0), 4'b0000, 3'b000,
                      ev(3'b001, 0, 4'b0010, 0, 0, 2'b00, 0));
        applyStimulus("bge",  OP_B,  3'b101, 7'b0000000, 0, 0, 3'b010,
                      ev(3'b001, 0, 4'b0001, 0, 0, 2'b00, 0), 4'b0000, 3'b000,
                      ev(3'b001, 0, 4'b0001, 0, 0, 2'b00, 0));
        applyStimulus("bf3_010", OP_B, 3'b010, 7'b0000000, 0, 0, 3'b010,
                      ev(3'b001, 0, 4'b0000, 0, 0, 2'b00, 0), 4'b0000, 3'b000,
                      ev(3'b001, 0, 4'b0000, 0, 0, 2'b00, 0));
        applyStimulus("jalFlush", OP_JAL, 3'b000, 7'b0000000, 0, 1, 3'b011, 13'd0, 4'b0000, 3'b000, 13'd0);
        applyStimulus("jal",  OP_JAL,  3'b000, 7'b0000000, 0, 0, 3'b011, eJal, 4'b0110, 3'b110, eJal);
        applyStimulus("jalr", OP_JALR, 3'b000, 7'b0000000, 0, 0, 3'b000, eJalr, 4'b0110, 3'b110, eJalr);
        applyStimulus("lui",  OP_LUI,  3'b000, 7'b0000000, 0, 0, 3'b100, eLui, 4'b0100, 3'b100, eLui);
        applyStimulus("addiF7", OP_I,  3'b000, 7'b0100000, 0, 0, 3'b000, eAddi, 4'b0100, 3'b100, eAddi);
        applyStimulus("and",  OP_R,  3'b111, 7'b0000000, 0, 0, 3'b000,
                      ev(3'b010, 0, 4'b0000, 0, 0, 2'b00, 1), 4'b0100, 3'b100,
                      ev(3'b010, 0, 4'b0000, 0, 0, 2'b00, 1));
        applyStimulus("or",   OP_R,  3'b110, 7'b0000000, 0, 0, 3'b000,
                      ev(3'b011, 0, 4'b0000, 0, 0, 2'b00, 1), 4'b0100, 3'b100,
                      ev(3'b011, 0, 4'b0000, 0, 0, 2'b00, 1));
        applyStimulus("slti", OP_I,  3'b010, 7'b0000000, 0, 0, 3'b000,
                      ev(3'b101, 1, 4'b0000, 0, 0, 2'b00, 1), 4'b0100, 3'b100,
                      ev(3'b101, 1, 4'b0000, 0, 0, 2'b00, 1));
        applyStimulus("xor",  OP_R,  3'b100, 7'b0000000, 0, 0, 3'b000,
                      ev(3'b111, 0, 4'b0000, 0, 0, 2'b00, 1), 4'b0100, 3'b100,
                      ev(3'b111, 0, 4'b0000, 0, 0, 2'b00, 1));
        applyStimulus("mul",  OP_R,  3'b000, 7'b0000001, 0, 0, 3'b000,
                      ev(MUL_CODE, 0, 4'b0000, 0, 0, 2'b00, 1), 4'b0100, 3'b100,
                      ev(MUL_CODE, 0, 4'b0000, 0, 0, 2'b00, 1));
        applyStimulus("stallFlush", OP_R, 3'b000, 7'b0000000, 1, 1, 3'b000, 13'd0, 4'b0000, 3'b000, 13'd0);
        applyStimulus("bubble", 7'd0, 3'b000, 7'b0000000, 0, 0, 3'b000, 13'd0, 4'b0000, 3'b000, 13'd0);

        // A halt under flush is discarded: done never rises, RUN continues.
        base = edges;
        push(K_D1, base + 4, "haltFlush/done", 16'd0);
        push(K_D1, base + 6, "haltFlush/doneLate", 16'd0);
        applyStimulus("haltFlush", OP_HALT, 3'b000, 7'b0000000, 0, 1, 3'b000, 13'd0, 4'b0000, 3'b000, 13'd0);
        applyStimulus("addAfterHF", OP_R, 3'b000, 7'b0000000, 0, 0, 3'b000, eAdd, 4'b0100, 3'b100, eAdd);
        applyStimulus("lwOld", OP_LW, 3'b010, 7'b0000000, 0, 0, 3'b000, eLw, 4'b0101, 3'b101, eLw);

        // Unknown op: halts the non-strict unit, is a NOP for the strict one.
        base = edges;
        push(K_D1, base + 3, "unkHalt/doneEarly", 16'd0);
        push(K_D1, base + 4, "unkHalt/done", 16'd1);
        push(K_D1, base + 6, "unkHalt/doneSticky", 16'd1);
        push(K_D2, base + 6, "unkHalt/done2", 16'd0);
        applyStimulus("unkHalt", OP_UNK, 3'b000, 7'b0000000, 0, 0, 3'b000, 13'd0, 4'b0000, 3'b000, 13'd0);
        for (int i = 0; i < 5; i++)
            applyStimulus($sformatf("drainAdd%0d", i), OP_R, 3'b000, 7'b0000000, 0, 0, 3'b000,
                          13'd0, 4'b0000, 3'b000, eAdd);
        repeat (3) step();

        // Reset in the middle of a drain aborts it.
        rst = 1'b1;
        step();
        rst = 1'b0;
        op_D = OP_HALT; func3_D = 3'd0; func7_D = 7'd0;
        step();
        op_D = 7'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        pushAllZero("midDrainRst");
        step();
        pushAllZero("midDrainRstHeld");
        step();
        rst = 1'b0;
        pushAllZero("afterRst");
        base = edges;
        push(K_D1, base + 5, "afterRst/done", 16'd0);
        applyStimulus("runAfterRst", OP_R, 3'b000, 7'b0000000, 0, 0, 3'b000, eAdd, 4'b0100, 3'b100, eAdd);
        repeat (4) applyStimulus("idle", 7'd0, 3'b000, 7'b0000000, 0, 0, 3'b000, 13'd0, 4'b0000, 3'b000, 13'd0);

        // HALT_OP with no stall: done after edge n+4 (delay 0) and n+7 (delay 3).
        base = edges;
        push(K_D1, base + 3, "halt/doneEarly", 16'd0);
        push(K_D1, base + 4, "halt/done", 16'd1);
        push(K_D1, base + 8, "halt/doneSticky", 16'd1);
        push(K_D2, base + 6, "halt/done2Early", 16'd0);
        push(K_D2, base + 7, "halt/done2", 16'd1);
        push(K_D2, base + 9, "halt/done2Sticky", 16'd1);
        applyStimulus("halt", OP_HALT, 3'b000, 7'b0000000, 0, 0, 3'b000, 13'd0, 4'b0000, 3'b000, 13'd0);
        for (int i = 0; i < 9; i++)
            applyStimulus($sformatf("postHalt%0d", i), OP_R, 3'b000, 7'b0000000, 0, 0, 3'b000,
                          13'd0, 4'b0000, 3'b000, 13'd0);
        repeat (5) step();

        foreach (sb[i]) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: never sampled, expected 'h%0h at edge %0d",
                     sb[i].name, sb[i].exp, sb[i].due);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
